// File: rtl/circuit_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// circuit_sweep_ctrl
//
// Drives an N_IN-input combinational circuit under test through every input
// combination. Each vector is held for SETTLE_CYCLES + 1 cycles. The circuit
// output f_in is sampled on the edge that ends that window, and the full truth
// table is built up in a register.
//
// Optional feature (compile-time macro SWEEP_GRAY_EN):
//   defined   - vectors are issued in Gray order, so only one input toggles
//               per step. truth is still indexed by the binary vector value.
//   undefined - vectors are issued in plain binary order.
//
// Ports:
//   clk         in   system clock, rising edge active
//   rst_n       in   synchronous active-low reset
//   start       in   begin a sweep (honoured only when idle)
//   abort       in   cancel a running sweep (wins over start when idle)
//   f_in        in   output of the circuit under test
//   vec_out     out  [N_IN]     vector driven to the circuit, MSB = first input
//   busy        out  1          sweep in progress
//   done        out  1          one-cycle pulse on normal completion
//   truth       out  [2^N_IN]   captured truth table, bit i = f(vec == i)
//   ones_count  out  [N_IN+1]   number of vectors that sampled f_in = 1
// -----------------------------------------------------------------------------
module circuit_sweep_ctrl #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   f_in,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   truth,
  output logic [N_IN:0]          ones_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  localparam logic [3:0]      SETTLE   = 4'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0] IDX_ZERO = {N_IN{1'b0}};
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(32'd1);
  // With no settle time the HOLD phase is skipped entirely.
  localparam state_t          LOAD_STATE = (SETTLE == 4'd0) ? S_SAMPLE : S_HOLD;

  state_t                 state_q, state_d;
  logic [N_IN-1:0]        idx_q, idx_d, idx_inc;
  logic [3:0]             cnt_q, cnt_d;
  logic [N_IN-1:0]        vec_q, vec_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [(1<<N_IN)-1:0]   truth_q, truth_d;
  logic [N_IN:0]          ones_q, ones_d;

  // Maps a sweep step index to the vector applied at that step.
  function automatic logic [N_IN-1:0] seq(input logic [N_IN-1:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  // Next-state and datapath: sweep sequencing, capture and abort handling.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    done_d  = 1'b0;
    truth_d = truth_q;
    ones_d  = ones_q;
    idx_inc = idx_q + IDX_ONE;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          truth_d = '0;
          ones_d  = '0;
          idx_d   = IDX_ZERO;
          vec_d   = seq(IDX_ZERO);
          cnt_d   = SETTLE;
          state_d = LOAD_STATE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
          vec_d   = IDX_ZERO;
        end else begin
          // HOLD lasts SETTLE cycles; the SAMPLE cycle makes it SETTLE + 1.
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_SAMPLE;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_SAMPLE: begin
        // The capture happens on this edge even if abort is also asserted,
        // so the aborted vector's result is kept with the partial table.
        truth_d[vec_q] = f_in;
        ones_d         = ones_q + {{N_IN{1'b0}}, f_in};
        if (abort) begin
          state_d = S_IDLE;
          vec_d   = IDX_ZERO;
        end else if (idx_q != IDX_LAST) begin
          idx_d   = idx_inc;
          vec_d   = seq(idx_inc);
          cnt_d   = SETTLE;
          state_d = LOAD_STATE;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        vec_d   = IDX_ZERO;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_ZERO;
      cnt_q   <= 4'd0;
      vec_q   <= IDX_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      truth_q <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      truth_q <= truth_d;
      ones_q  <= ones_d;
    end
  end

  assign vec_out    = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign truth      = truth_q;
  assign ones_count = ones_q;

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_circuit_sweep_ctrl
//
// Two instances share start/abort/rst_n: u_dut0 with SETTLE_CYCLES = 2 and
// u_dut1 with SETTLE_CYCLES = 0. Each instance's circuit under test is a
// truth-table lookup f = func[vec_out], with func chosen when a sweep starts.
// The driver keeps a per-sweep model (start cycle, function) and pushes the
// expected end-of-sweep record when the ending edge is issued. The monitor
// pops a record whenever busy falls and also checks the vector schedule each
// cycle. Compile with +define+SWEEP_GRAY_EN to exercise Gray order.
// -----------------------------------------------------------------------------
module tb_circuit_sweep_ctrl;

  typedef struct packed {
    logic        done;
    logic [7:0]  truth;
    logic [3:0]  ones;
    logic [2:0]  vec;
    logic [31:0] cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       f_s     [2];
  logic [2:0] vec_s   [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic [7:0] truth_s [2];
  logic [3:0] ones_s  [2];

  // Model state, written only by the driver.
  int         cyc;
  logic       m_active [2];
  int         m_start  [2];
  logic [7:0] m_func   [2];
  logic [7:0] m_truth  [2];
  logic [3:0] m_ones   [2];
  logic [2:0] m_idle_vec [2];
  logic [7:0] nf       [2];
  exp_t       q0[$];
  exp_t       q1[$];

  logic mon_en;
  logic end_req;
  logic mon_done;
  int   n_chk;
  int   n_pass;

  circuit_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_s[0]),
    .vec_out(vec_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .truth(truth_s[0]), .ones_count(ones_s[0])
  );

  circuit_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_s[1]),
    .vec_out(vec_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .truth(truth_s[1]), .ones_count(ones_s[1])
  );

  assign f_s[0] = m_func[0][vec_s[0]];
  assign f_s[1] = m_func[1][vec_s[1]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int per(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic logic [2:0] seq(input int j);
    logic [2:0] b;
    b = j[2:0];
`ifdef SWEEP_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic logic [3:0] pop8(input logic [7:0] v);
    int c;
    c = 0;
    for (int k = 0; k < 8; k++) c += int'(v[k]);
    return 4'(c);
  endfunction

  task automatic push_exp(input int i, input exp_t r);
    if (i == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Apply one clock edge of stimulus and advance the reference model.
  task automatic step(input logic st, input logic ab, input logic rs);
    exp_t       r;
    int         k;
    logic [7:0] part;
    start = st;
    abort = ab;
    rst_n = !rs;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rs) begin
        if (m_active[i]) begin
          r = '{done: 1'b0, truth: 8'h00, ones: 4'd0, vec: 3'd0, cyc: cyc};
          push_exp(i, r);
        end
        m_active[i]   = 1'b0;
        m_truth[i]    = 8'h00;
        m_ones[i]     = 4'd0;
        m_idle_vec[i] = 3'd0;
      end else if (m_active[i]) begin
        if (ab) begin
          // Vectors whose sample edge has arrived (including this one).
          k = (cyc - m_start[i]) / per(i);
          if (k > 8) k = 8;
          part = 8'h00;
          for (int j = 0; j < k; j++) part[seq(j)] = m_func[i][seq(j)];
          r = '{done: 1'b0, truth: part, ones: pop8(part), vec: 3'd0, cyc: cyc};
          push_exp(i, r);
          m_active[i]   = 1'b0;
          m_truth[i]    = part;
          m_ones[i]     = pop8(part);
          m_idle_vec[i] = 3'd0;
        end else if (cyc - m_start[i] == 8 * per(i)) begin
          r = '{done: 1'b1, truth: m_func[i], ones: pop8(m_func[i]), vec: seq(7), cyc: cyc};
          push_exp(i, r);
          m_active[i]   = 1'b0;
          m_truth[i]    = m_func[i];
          m_ones[i]     = pop8(m_func[i]);
          m_idle_vec[i] = seq(7);
        end
      end else if (st && !ab) begin
        m_active[i] = 1'b1;
        m_start[i]  = cyc;
        m_func[i]   = nf[i];
      end
    end
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h, expected %0h (cycle %0d)", nm, idx, act, exp, cyc);
  endtask

  // Monitor: scoreboard pop on every sweep end, per-cycle schedule checks.
  initial begin
    logic bprev [2];
    logic fall;
    logic exp_done;
    exp_t r;
    bprev[0] = 1'b0;
    bprev[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < 2; i++) begin
          fall     = bprev[i] && !busy_s[i];
          exp_done = 1'b0;
          if (fall) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
              n_chk++;
              $display("FAIL sb_unexpected_end[%0d]: busy fell at cycle %0d, no sweep end expected", i, cyc);
            end else begin
              if (i == 0) r = q0.pop_front();
              else        r = q1.pop_front();
              exp_done = r.done;
              chk("end_cycle", i, 32'(cyc), r.cyc);
              chk("end_truth", i, 32'(truth_s[i]), 32'(r.truth));
              chk("end_ones",  i, 32'(ones_s[i]),  32'(r.ones));
              chk("end_vec",   i, 32'(vec_s[i]),   32'(r.vec));
            end
          end
          chk("done", i, 32'(done_s[i]), 32'(exp_done));
          chk("busy", i, 32'(busy_s[i]), 32'(m_active[i]));
          if (m_active[i]) begin
            chk("vec_sweep", i, 32'(vec_s[i]), 32'(seq((cyc - m_start[i]) / per(i))));
          end else begin
            chk("vec_idle",   i, 32'(vec_s[i]),   32'(m_idle_vec[i]));
            chk("truth_idle", i, 32'(truth_s[i]), 32'(m_truth[i]));
            chk("ones_idle",  i, 32'(ones_s[i]),  32'(m_ones[i]));
          end
          bprev[i] = busy_s[i];
        end
        if (end_req && !mon_done) begin
          chk("sb_drain", 0, 32'(q0.size()), 32'd0);
          chk("sb_drain", 1, 32'(q1.size()), 32'd0);
          mon_done = 1'b1;
        end
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    cyc      = 0;
    mon_en   = 1'b0;
    end_req  = 1'b0;
    mon_done = 1'b0;
    n_chk    = 0;
    n_pass   = 0;
    start    = 1'b0;
    abort    = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_active[i]   = 1'b0;
      m_start[i]    = 0;
      m_func[i]     = 8'h00;
      m_truth[i]    = 8'h00;
      m_ones[i]     = 4'd0;
      m_idle_vec[i] = 3'd0;
      nf[i]         = 8'h00;
    end

    // Reset state.
    step(1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Full sweeps: (a&b)|c with settle 2, a^b^c with settle 0.
    nf[0] = 8'hEA;
    nf[1] = 8'h96;
    step(1'b1, 1'b0, 1'b0);
    repeat (28) step(1'b0, 1'b0, 1'b0);

    // Abort on the sample edge of vector 3 (settle-2 instance), f = 1.
    nf[0] = 8'hFF;
    nf[1] = 8'hFF;
    step(1'b1, 1'b0, 1'b0);
    repeat (11) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted.
    nf[0] = 8'h5C;
    nf[1] = 8'h3A;
    step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (18) step(1'b0, 1'b0, 1'b0);
    nf[0] = 8'hC3;
    nf[1] = 8'h81;
    step(1'b1, 1'b0, 1'b0);
    repeat (26) step(1'b0, 1'b0, 1'b0);

    // Start and abort together while idle: nothing starts.
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Synchronous reset at vector 5, then a clean sweep.
    nf[0] = 8'hEA;
    nf[1] = 8'h69;
    step(1'b1, 1'b0, 1'b0);
    repeat (15) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (26) step(1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    repeat (3000) begin
      nf[0] = 8'($urandom);
      nf[1] = 8'($urandom);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
    end
    repeat (40) step(1'b0, 1'b0, 1'b0);

    end_req = 1'b1;
    for (int w = 0; w < 10 && !mon_done; w++) @(negedge clk);
    #1;
    if (!mon_done) begin
      $display("FAIL monitor_final: final checks did not run");
      n_chk++;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
